// File: rtl/key_event_scheduler_pkg.sv
// key_event_scheduler shared types
// Event record, index width and repeat FSM states.
package key_sched_pkg;

   localparam int NUM_KEYS_DEF = 4;
   localparam int SW_W_DEF     = 10;
   localparam int KEY_IDX_W    = $clog2(NUM_KEYS_DEF);

   typedef struct packed {
      logic [KEY_IDX_W-1:0] key;
      logic [SW_W_DEF-1:0]  sw;
      logic                 rpt;
   } key_event_t;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rep_state_t;

endpackage

// File: rtl/key_event_scheduler_if.sv
// key_event_scheduler port bundle
// Key strobes in, tagged event stream and status out.
interface key_event_scheduler_if #(
   parameter int NUM_KEYS = 4,
   parameter int SW_W     = 10
);
   localparam int KW = $clog2(NUM_KEYS);

   logic [NUM_KEYS-1:0] key_pressed;
   logic [NUM_KEYS-1:0] key_level_n;
   logic [SW_W-1:0]     sw;
   logic                ev_valid;
   logic                ev_ready;
   logic [KW-1:0]       ev_key;
   logic [SW_W-1:0]     ev_sw;
   logic                ev_repeat;
   logic [NUM_KEYS-1:0] pending;
   logic                overflow;
   logic                overflow_clr;

   modport slave (
      input  key_pressed, key_level_n, sw,
      input  ev_ready, overflow_clr,
      output ev_valid, ev_key, ev_sw,
      output ev_repeat, pending, overflow
   );

   modport master (
      output key_pressed, key_level_n, sw,
      output ev_ready, overflow_clr,
      input  ev_valid, ev_key, ev_sw,
      input  ev_repeat, pending, overflow
   );

endinterface

// File: rtl/key_event_fifo.sv
// key_event_fifo: first-word-fall-through queue
// Head word is visible whenever not empty.
module key_event_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          wr_en, rd_en;

   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // storage needs no reset; empty gates the head
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // pointers wrap naturally at power-of-two depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !rd_en) count <= count + 1'b1;
         else if (!wr_en && rd_en) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: round-robin key press queue
// Optional auto-repeat engine enabled by KEY_AUTOREPEAT_EN.
module key_event_scheduler
   import key_sched_pkg::*;
#(
   parameter int NUM_KEYS      = NUM_KEYS_DEF,
   parameter int SW_W          = SW_W_DEF,
   parameter int FIFO_DEPTH    = 4,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   key_event_scheduler_if.slave  bus
);

   localparam int KW = $clog2(NUM_KEYS);
   localparam int EW = KW + SW_W + 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [KW-1:0]   key;
      logic [SW_W-1:0] sw;
      logic            rpt;
   } ev_t;

   logic [NUM_KEYS-1:0] pend, rflag, rep_req, new_req, gnt;
   logic [KW-1:0]       ptr, gidx;
   logic                gvalid, push, pop, full, empty;
   logic                ovf, merge;
   logic [AW:0]         unused_count;
   ev_t                 wr_ev, rd_ev;

   assign pop     = bus.ev_ready & ~empty;
   assign push    = gvalid & (~full | pop);
   assign new_req = bus.key_pressed | rep_req;
   assign merge   = |(new_req & pend & ~gnt);
   assign wr_ev   = '{key: gidx, sw: bus.sw, rpt: rflag[gidx]};

   // round-robin search starting after last grant
   always_comb begin
      gvalid = 1'b0;
      gidx   = '0;
      for (int i = 1; i <= NUM_KEYS; i++) begin
         if (!gvalid && pend[(int'(ptr) + i) % NUM_KEYS]) begin
            gvalid = 1'b1;
            gidx   = KW'((int'(ptr) + i) % NUM_KEYS);
         end
      end
   end

   // one-hot grant, only when the queue takes it
   always_comb begin
      gnt = '0;
      if (push) gnt[gidx] = 1'b1;
   end

   // request latch, repeat tag, pointer, sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend  <= '0;
         rflag <= '0;
         ptr   <= '0;
         ovf   <= 1'b0;
      end else begin
         pend <= (pend & ~gnt) | new_req;
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (new_req[k] && !(pend[k] && !gnt[k]))
               rflag[k] <= rep_req[k] & ~bus.key_pressed[k];
         end
         if (push) ptr <= gidx;
         if (merge) ovf <= 1'b1;
         else if (bus.overflow_clr) ovf <= 1'b0;
      end
   end

   key_event_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (wr_ev),
      .pop   (pop),
      .dout  (rd_ev),
      .full  (full),
      .empty (empty),
      .count (unused_count)
   );

   assign bus.ev_valid  = ~empty;
   assign bus.ev_key    = empty ? '0 : rd_ev.key;
   assign bus.ev_sw     = empty ? '0 : rd_ev.sw;
   assign bus.ev_repeat = empty ? 1'b0 : rd_ev.rpt;
   assign bus.pending   = pend;
   assign bus.overflow  = ovf;

`ifdef KEY_AUTOREPEAT_EN
   rep_state_t          state, state_n;
   logic [31:0]         cnt, cnt_n;
   logic [KW-1:0]       rkey, rkey_n, low_any, low_other;
   logic [NUM_KEYS-1:0] other;
   logic                other_any;

   assign other     = bus.key_pressed & ~(NUM_KEYS'(1) << rkey);
   assign other_any = |other;

   // lowest-index pressed key, overall and excluding target
   always_comb begin
      low_any   = '0;
      low_other = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (bus.key_pressed[i]) low_any = KW'(i);
         if (other[i]) low_other = KW'(i);
      end
   end

   // repeat state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         rkey  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         rkey  <= rkey_n;
      end
   end

   // repeat next state: a new press retargets, release idles
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rkey_n  = rkey;
      unique case (state)
         IDLE: begin
            if (|bus.key_pressed) begin
               state_n = DELAY;
               rkey_n  = low_any;
               cnt_n   = 32'(REPEAT_DELAY - 1);
            end
         end
         DELAY, REPEAT: begin
            if (other_any) begin
               state_n = DELAY;
               rkey_n  = low_other;
               cnt_n   = 32'(REPEAT_DELAY - 1);
            end else if (bus.key_level_n[rkey]) begin
               state_n = IDLE;
            end else if (cnt == '0) begin
               state_n = REPEAT;
               cnt_n   = 32'(REPEAT_PERIOD - 1);
            end else begin
               cnt_n = cnt - 32'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // repeat request when the held key's counter expires
   always_comb begin
      rep_req = '0;
      if (state != IDLE && !other_any &&
          !bus.key_level_n[rkey] && cnt == '0)
         rep_req[rkey] = 1'b1;
   end
`else
   logic unused_cfg;

   assign rep_req    = '0;
   assign unused_cfg = ^{bus.key_level_n,
                         REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: directed self-checking bench
// Repeat section compiles in with KEY_AUTOREPEAT_EN.
module tb_key_event_scheduler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   key_event_scheduler_if #(.NUM_KEYS(4), .SW_W(10)) bus ();

   key_event_scheduler #(
      .NUM_KEYS      (4),
      .SW_W          (10),
      .FIFO_DEPTH    (4),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seq [6];
      seq = '{2, 3, 0, 1, 2, 3};
      bus.key_pressed  = '0;
      bus.key_level_n  = '1;
      bus.sw           = '0;
      bus.ev_ready     = 1'b0;
      bus.overflow_clr = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", bus.ev_valid, 0);
      check("rst_pend", bus.pending, 0);
      check("rst_ovf", bus.overflow, 0);
      check("rst_key", bus.ev_key, 0);
      check("rst_sw", bus.ev_sw, 0);
      check("rst_rpt", bus.ev_repeat, 0);
      rst_n = 1'b1;
      step();

      // single press, two-cycle latency
      bus.key_pressed = 4'b0100;
      bus.sw = 10'h155;
      bus.ev_ready = 1'b1;
      step();
      bus.key_pressed = '0;
      check("t1_pend", bus.pending, 4'b0100);
      check("t1_early", bus.ev_valid, 0);
      step();
      check("t1_valid", bus.ev_valid, 1);
      check("t1_key", bus.ev_key, 2);
      check("t1_sw", bus.ev_sw, 10'h155);
      check("t1_rpt", bus.ev_repeat, 0);
      check("t1_pclr", bus.pending, 0);
      bus.sw = '0;
      step();
      check("t1_once", bus.ev_valid, 0);

      // simultaneous presses, pointer at 2, sw sampled at grant
      bus.key_pressed = 4'b1011;
      step();
      bus.key_pressed = '0;
      bus.sw = 10'h001;
      step();
      check("t2_k0", bus.ev_key, 3);
      check("t2_s0", bus.ev_sw, 10'h001);
      bus.sw = 10'h002;
      step();
      check("t2_k1", bus.ev_key, 0);
      check("t2_s1", bus.ev_sw, 10'h002);
      bus.sw = 10'h003;
      step();
      check("t2_k2", bus.ev_key, 1);
      check("t2_s2", bus.ev_sw, 10'h003);
      check("t2_v2", bus.ev_valid, 1);
      bus.sw = '0;
      step();
      check("t2_end", bus.ev_valid, 0);

      // backpressure: queue fills, pending holds the rest
      bus.ev_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.key_pressed = 4'b0001 << seq[i];
         step();
      end
      bus.key_pressed = '0;
      check("t3_pend", bus.pending, 4'b1100);
      step();
      step();
      check("t3_hold", bus.pending, 4'b1100);
      check("t3_ovf", bus.overflow, 0);
      check("t3_head", bus.ev_key, 2);
      bus.ev_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("t3_v", bus.ev_valid, 1);
         check("t3_k", bus.ev_key, seq[i]);
         step();
      end
      check("t3_end", bus.ev_valid, 0);
      check("t3_ovf2", bus.overflow, 0);

      // overflow on merged press while queue full
      bus.ev_ready = 1'b0;
      bus.key_pressed = 4'b1111;
      step();
      bus.key_pressed = '0;
      repeat (4) step();
      check("t4_full", bus.pending, 0);
      check("t4_head", bus.ev_key, 0);
      bus.key_pressed = 4'b0010;
      step();
      check("t4_p1", bus.pending, 4'b0010);
      check("t4_no", bus.overflow, 0);
      step();
      bus.key_pressed = '0;
      check("t4_ovf", bus.overflow, 1);
      check("t4_p2", bus.pending, 4'b0010);
      bus.overflow_clr = 1'b1;
      step();
      check("t4_clr", bus.overflow, 0);
      bus.key_pressed = 4'b0010;
      step();
      bus.key_pressed = '0;
      bus.overflow_clr = 1'b0;
      check("t4_both", bus.overflow, 1);

      // asynchronous reset discards queue and pending
      #2 rst_n = 1'b0;
      #1;
      check("t5_valid", bus.ev_valid, 0);
      check("t5_pend", bus.pending, 0);
      check("t5_ovf", bus.overflow, 0);
      step();
      step();
      rst_n = 1'b1;
      bus.ev_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t5_none", bus.ev_valid, 0);
      end

`ifdef KEY_AUTOREPEAT_EN
      // hold key 0 for 30 cycles
      bus.key_pressed = 4'b0001;
      bus.key_level_n = 4'b1110;
      step();
      bus.key_pressed = '0;
      for (int c = 1; c <= 40; c++) begin
         logic ev;
         if (c == 30) bus.key_level_n = '1;
         ev = (c == 2) || (c == 12) || (c == 16) ||
              (c == 20) || (c == 24) || (c == 28);
         check("t6_v", bus.ev_valid, ev);
         if (ev) begin
            check("t6_k", bus.ev_key, 0);
            check("t6_r", bus.ev_repeat, c != 2);
         end
         step();
      end
      check("t6_ovf", bus.overflow, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
